caravel_wb_buttons_leds: RTL and testbench

CARAVEL_WB_BUTTONS_LEDS -- requirements
Module: caravel_wb_buttons_leds

---
 rtl/caravel_wb_buttons_leds_if.sv | 22 ++
 rtl/caravel_wb_buttons_leds.sv | 94 +++++++++
 tb/tb_caravel_wb_buttons_leds.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/caravel_wb_buttons_leds_if.sv
// Wishbone slave bus bundle for the buttons/LEDs register block.
// The signal names match the Caravel user-project wrapper.
interface caravel_wb_buttons_leds_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/caravel_wb_buttons_leds.sv
// Wishbone register block that drives 8 LEDs and samples 3 buttons.
// It latches rising edges on the buttons and raises a maskable interrupt.
module caravel_wb_buttons_leds #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          BTN_PIN   = 7,
   parameter int          LED_PIN   = 10
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   caravel_wb_buttons_leds_if.slave      wbs,
   input  logic [37:0]                   io_in,
   output logic [37:0]                   io_out,
   output logic [37:0]                   io_oeb,
   output logic                          irq
);

   logic [7:0] led_q;
   logic [2:0] irqen_q;
   logic [2:0] edge_q;
   logic [2:0] btn_meta;
   logic [2:0] btn_sync;
   logic [2:0] btn_prev;
   logic       ack_q;
   logic [31:0] dat_q;

   logic        hit;
   logic        take;
   logic        wr_en;
   logic [1:0]  offset;
   logic [2:0]  edge_clr;
   logic [2:0]  edge_rise;
   logic [31:0] rd_data;

   // A request is taken only on the cycle ack is low, so a held strobe
   // cannot produce a second ack back to back.
   assign hit      = wbs.wbs_cyc_i & wbs.wbs_stb_i
                     & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign take     = hit & ~ack_q;
   assign offset   = wbs.wbs_adr_i[3:2];
   assign wr_en    = take & wbs.wbs_we_i & wbs.wbs_sel_i[0];
   assign edge_clr = (wr_en && offset == 2'd2) ? wbs.wbs_dat_i[2:0] : 3'b000;
   assign edge_rise = btn_sync & ~btn_prev;

   always_comb begin
      rd_data = '0;
      case (offset)
         2'd0: rd_data[7:0] = led_q;
         2'd1: rd_data[2:0] = btn_sync;
         2'd2: rd_data[2:0] = edge_q;
         2'd3: rd_data[2:0] = irqen_q;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         led_q    <= '0;
         irqen_q  <= '0;
         edge_q   <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
         btn_prev <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         irq      <= 1'b0;
      end else begin
         btn_meta <= io_in[BTN_PIN+2:BTN_PIN];
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         ack_q    <= take;
         dat_q    <= (take && !wbs.wbs_we_i) ? rd_data : 32'h0;
         if (wr_en && offset == 2'd0) led_q   <= wbs.wbs_dat_i[7:0];
         if (wr_en && offset == 2'd3) irqen_q <= wbs.wbs_dat_i[2:0];
         // A new edge wins over a clear arriving on the same cycle.
         edge_q   <= (edge_q & ~edge_clr) | edge_rise;
         irq      <= |(edge_q & irqen_q);
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;

   always_comb begin
      io_out = '0;
      io_out[LED_PIN +: 8] = led_q;
      io_oeb = '1;
      io_oeb[LED_PIN +: 8] = 8'h00;
   end

   // Only a few pad inputs and the low data byte are used by this block.
   logic unused_bits;
   assign unused_bits = &{1'b0, io_in, wbs.wbs_dat_i, wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0]};

endmodule

// File: tb/tb_caravel_wb_buttons_leds.sv
// Directed bench for caravel_wb_buttons_leds: a table of register accesses,
// then hand-written sequences for the edge, interrupt, address-miss and reset cases.
module tb_caravel_wb_buttons_leds;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk;
   logic        rst;
   logic [37:0] io_in;
   logic [37:0] io_out;
   logic [37:0] io_oeb;
   logic        irq;

   int n_checks = 0;
   int n_err    = 0;

   caravel_wb_buttons_leds_if bus ();

   caravel_wb_buttons_leds #(.BASE_ADDR(BASE), .BTN_PIN(7), .LED_PIN(10)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (bus),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] wdat;
      logic [31:0] exp_rd;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one transfer, wait a bounded number of cycles for ack (lat=99 if none),
   // then release the bus and confirm ack/data return to idle.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wdat, output logic [31:0] rdat, output int lat);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      rdat = '0;
      lat  = 99;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (bus.wbs_ack_o) begin
            lat  = i;
            rdat = bus.wbs_dat_o;
            break;
         end
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk); #1;
      if (lat != 99) begin
         check("ack_drop", {63'b0, bus.wbs_ack_o}, 64'd0);
         check("dat_idle", {32'b0, bus.wbs_dat_o}, 64'd0);
      end
   endtask

   logic [31:0] rd;
   int          lat;
   logic [37:0] exp_oeb;
   logic [37:0] other_mask;

   initial begin
      exp_oeb    = ~(38'hFF << 10);
      other_mask = ~(38'hFF << 10);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      io_in = '0;
      rst   = 1'b1;

      vecs[0]  = '{1'b0, BASE + 32'h00, 4'h1, 32'h0,        32'h0,  8'h00};
      vecs[1]  = '{1'b0, BASE + 32'h0C, 4'h1, 32'h0,        32'h0,  8'h00};
      vecs[2]  = '{1'b1, BASE + 32'h00, 4'h1, 32'hFF,       32'h0,  8'hFF};
      vecs[3]  = '{1'b0, BASE + 32'h00, 4'h1, 32'h0,        32'hFF, 8'hFF};
      vecs[4]  = '{1'b1, BASE + 32'h00, 4'h0, 32'h12,       32'h0,  8'hFF};
      vecs[5]  = '{1'b0, BASE + 32'h00, 4'h1, 32'h0,        32'hFF, 8'hFF};
      vecs[6]  = '{1'b1, BASE + 32'h00, 4'h1, 32'hA5,       32'h0,  8'hA5};
      vecs[7]  = '{1'b0, BASE + 32'h03, 4'h1, 32'h0,        32'hA5, 8'hA5};
      vecs[8]  = '{1'b1, BASE + 32'h0C, 4'hF, 32'hFFFFFFFF, 32'h0,  8'hA5};
      vecs[9]  = '{1'b0, BASE + 32'h0C, 4'h1, 32'h0,        32'h7,  8'hA5};
      vecs[10] = '{1'b1, BASE + 32'h0C, 4'h1, 32'h1,        32'h0,  8'hA5};
      vecs[11] = '{1'b0, BASE + 32'h0C, 4'h1, 32'h0,        32'h1,  8'hA5};
      vecs[12] = '{1'b1, BASE + 32'h04, 4'h1, 32'h7,        32'h0,  8'hA5};
      vecs[13] = '{1'b0, BASE + 32'h04, 4'h1, 32'h0,        32'h0,  8'hA5};
      vecs[14] = '{1'b0, BASE + 32'h08, 4'h1, 32'h0,        32'h0,  8'hA5};
      vecs[15] = '{1'b1, BASE + 32'h00, 4'hE, 32'h3C,       32'h0,  8'hA5};

      repeat (3) @(posedge clk);
      #1;
      check("rst_oeb", {26'b0, io_oeb}, {26'b0, exp_oeb});
      check("rst_out", {26'b0, io_out}, 64'd0);
      check("rst_ack", {63'b0, bus.wbs_ack_o}, 64'd0);
      check("rst_irq", {63'b0, irq}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 16; v++) begin
         wb_xfer(vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].wdat, rd, lat);
         check($sformatf("ack_lat[%0d]", v), lat, 1);
         if (!vecs[v].we) check($sformatf("rdata[%0d]", v), {32'b0, rd}, {32'b0, vecs[v].exp_rd});
         check($sformatf("led[%0d]", v), {56'b0, io_out[17:10]}, {56'b0, vecs[v].exp_led});
         check($sformatf("io_out_other[%0d]", v), {26'b0, io_out & other_mask}, 64'd0);
         check($sformatf("oeb[%0d]", v), {26'b0, io_oeb}, {26'b0, exp_oeb});
      end

      // Strobe held high past the ack: ack must drop on the next cycle.
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h1; bus.wbs_adr_i = BASE;
      @(posedge clk); #1;
      check("held_ack1", {63'b0, bus.wbs_ack_o}, 64'd1);
      check("held_dat", {32'b0, bus.wbs_dat_o}, 64'hA5);
      @(posedge clk); #1;
      check("held_ack2", {63'b0, bus.wbs_ack_o}, 64'd0);
      check("held_dat2", {32'b0, bus.wbs_dat_o}, 64'd0);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(posedge clk); #1;

      // Button 0 rises with IRQEN=1: meta, sync, edge, then irq.
      io_in[7] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("irq_pre", {63'b0, irq}, 64'd0);
      @(posedge clk); #1;
      check("irq_set", {63'b0, irq}, 64'd1);
      wb_xfer(1'b0, BASE + 32'h08, 4'h1, 32'h0, rd, lat);
      check("edge_rd", {32'b0, rd}, 64'h1);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'h1; bus.wbs_adr_i = BASE + 32'h08; bus.wbs_dat_i = 32'h1;
      @(posedge clk); #1;
      check("w1c_ack", {63'b0, bus.wbs_ack_o}, 64'd1);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(posedge clk); #1;
      check("irq_clr", {63'b0, irq}, 64'd0);
      wb_xfer(1'b0, BASE + 32'h08, 4'h1, 32'h0, rd, lat);
      check("edge_clr", {32'b0, rd}, 64'h0);

      // Remaining buttons rise; they are masked so irq stays low.
      io_in[9:8] = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      wb_xfer(1'b0, BASE + 32'h04, 4'h1, 32'h0, rd, lat);
      check("btn_rd", {32'b0, rd}, 64'h7);
      wb_xfer(1'b1, BASE + 32'h00, 4'h1, 32'hFF, rd, lat);
      check("led_ff", {56'b0, io_out[17:10]}, 64'hFF);
      wb_xfer(1'b0, BASE + 32'h08, 4'h1, 32'h0, rd, lat);
      check("edge_masked", {32'b0, rd}, 64'h6);
      check("irq_masked", {63'b0, irq}, 64'd0);

      // Clear all edges, release button 0, then make its new edge land
      // on the same cycle as a W1C write to that bit.
      wb_xfer(1'b1, BASE + 32'h08, 4'h1, 32'h7, rd, lat);
      io_in[7] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      io_in[7] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      wb_xfer(1'b1, BASE + 32'h08, 4'h1, 32'h1, rd, lat);
      wb_xfer(1'b0, BASE + 32'h08, 4'h1, 32'h0, rd, lat);
      check("edge_set_wins", {32'b0, rd}, 64'h1);

      // A write outside the block is neither acked nor applied.
      wb_xfer(1'b1, BASE + 32'h100, 4'h1, 32'h00, rd, lat);
      check("miss_noack", lat, 99);
      check("miss_led", {56'b0, io_out[17:10]}, 64'hFF);

      // Reset while a write is pending: no ack, LED cleared and not updated.
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
      bus.wbs_sel_i = 4'h1; bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h55;
      #2 rst = 1'b1;
      #1;
      check("arst_led", {56'b0, io_out[17:10]}, 64'h0);
      @(posedge clk); #1;
      check("rstw_ack", {63'b0, bus.wbs_ack_o}, 64'd0);
      check("rstw_irq", {63'b0, irq}, 64'd0);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rstw_led", {56'b0, io_out[17:10]}, 64'h0);
      wb_xfer(1'b0, BASE + 32'h0C, 4'h1, 32'h0, rd, lat);
      check("rst_irqen", {32'b0, rd}, 64'h0);
      wb_xfer(1'b1, BASE + 32'h00, 4'h1, 32'h33, rd, lat);
      check("post_rst_lat", lat, 1);
      wb_xfer(1'b0, BASE + 32'h00, 4'h1, 32'h0, rd, lat);
      check("post_rst_rd", {32'b0, rd}, 64'h33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
